regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the CPU register file's single write port between two writeback requesters: A (ALU result) and B (memory load). Uses round-robin arbitration with valid/ready handshakes and drives the register file's write, w_addr and in inputs from a registered output stage. Keeps a per-register pending-write scoreboard so the issue logic can stall reads of registers that still have an outstanding write.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-low reset
hold  input  1  when high, no grant is issued this cycle
a_valid  input  1  requester A has a write
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
a_ready  output  1  A handshake accepted this cycle
b_valid  input  1  requester B has a write
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
b_ready  output  1  B handshake accepted this cycle
rsv_valid  input  1  reserve (mark busy) register rsv_addr
rsv_addr  input  ADDR_W  register being reserved
r_addr1  input  ADDR_W  read port 1 address (query)
r_addr2  input  ADDR_W  read port 2 address (query)
busy1  output  1  r_addr1 has a pending write
busy2  output  1  r_addr2 has a pending write
busy_vec  output  NUM_REGS  full scoreboard
rf_write  output  1  register file write enable
rf_w_addr  output  ADDR_W  register file write address
rf_in  output  DATA_W  register file write data
last_grant  output  1  0 = A granted last, 1 = B granted last

Behaviour:
- Reset (reset=0, async): rf_write=0, rf_w_addr=0, rf_in=0, busy_vec=0, last_grant=1 so A wins the first tie. Any in-flight rf_write is dropped, with no partial write.
- Ready logic is combinational from valid, hold and last_grant. At most one of a_ready/b_ready is high in any cycle. Both are 0 while hold=1 or reset=0.
- Arbitration when hold=0:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant, last_grant unchanged.
- Handshake occurs when x_valid & x_ready at a rising edge. On that edge:
  - rf_w_addr and rf_in capture the winner's addr and data.
  - rf_write goes to 1.
  - last_grant updates to the winner.
- Latency: the write is presented to the register file exactly one cycle after the handshake. rf_write is 1 for one cycle per handshake, and stays high across back-to-back grants.
- If there is no handshake on an edge, rf_write goes to 0. rf_w_addr and rf_in hold their previous values.
- Requesters hold valid, addr and data stable until ready. A requester must not drop valid before ready.
- Scoreboard:
  - rsv_valid sets busy_vec[rsv_addr] on the edge.
  - A handshake clears busy_vec[winner addr] on the same edge, so busy drops in the cycle rf_write is high.
  - Set and clear of the same register on the same edge: set wins (a new reservation is outstanding).
  - Reserving an already-busy register leaves it busy. There is no counting; one write clears it.
  - A write to a non-busy register is legal and leaves the bit 0.
- busy1 = busy_vec[r_addr1] and busy2 = busy_vec[r_addr2], combinational, with no bypass.
- A and B writing the same address in consecutive grants: both are issued in grant order, and the last write wins in the register file.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; GRANT_A=1'b0 and GRANT_B=1'b1 encodings.
- One sub-module, rr_arbiter2: two-way round-robin grant with hold and last_grant state. The scoreboard and output register stay in the top module.

Test Plan:
- Reset: assert reset=0 mid-operation with rf_write=1 and busy_vec=8'h24 -> all outputs 0 immediately, last_grant=1.
- Single requester: A writes 8'h0F to R2, hold=0 -> a_ready=1 that cycle; next cycle rf_write=1, rf_w_addr=2, rf_in=8'h0F; following cycle rf_write=0.
- Tie: A (R1, 8'hAA) and B (R3, 8'h55) valid continuously from reset -> grants A, B, A, B in order; rf_write stays high on consecutive cycles; last_grant toggles 0,1,0,1.
- Hold: both valid with hold=1 for 3 cycles -> a_ready=b_ready=0 and rf_write=0 throughout; first grant after hold drops follows last_grant.
- Scoreboard: rsv R5, then r_addr1=5 -> busy1=1; A writes R5 -> busy_vec[5]=0 in the rf_write cycle, busy1=0.
- Scoreboard set/clear collision: same edge with rsv R4 and B handshake to R4 -> busy_vec[4]=1 afterwards; a second write to R4 clears it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic {
    LAST_A = GRANT_A,
    LAST_B = GRANT_B
  } last_grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with hold; remembers the last winner so ties alternate.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant_c,
  output logic b_grant_c,
  output logic last_grant
);

  last_grant_e state_q;
  last_grant_e state_d;

  // State register; after reset B counts as last winner so A takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LAST_B;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_grant_c = 1'b0;
    b_grant_c = 1'b0;
    if (reset && !hold) begin
      if (a_valid && (!b_valid || state_q == LAST_B)) begin
        a_grant_c = 1'b1;
        state_d   = LAST_A;
      end else if (b_valid) begin
        b_grant_c = 1'b1;
        state_d   = LAST_B;
      end
    end
  end

  assign last_grant = (state_q == LAST_B);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writeback,
// with a registered write stage and a pending-write scoreboard for issue stalls.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [ADDR_W-1:0]   r_addr1,
  input  logic [ADDR_W-1:0]   r_addr2,
  output logic                busy1,
  output logic                busy2,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_w_addr,
  output logic [DATA_W-1:0]   rf_in,
  output logic                last_grant
);

  logic          a_grant_c;
  logic          b_grant_c;
  logic          hs_c;
  wr_req_t       win_c;
  logic [NUM_REGS-1:0] busy_d;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .a_grant_c  (a_grant_c),
    .b_grant_c  (b_grant_c),
    .last_grant (last_grant)
  );

  assign a_ready = a_grant_c;
  assign b_ready = b_grant_c;
  assign hs_c    = a_grant_c | b_grant_c;

  always_comb begin
    win_c = '{addr: a_addr, data: a_data};
    if (b_grant_c) begin
      win_c = '{addr: b_addr, data: b_data};
    end
  end

  // Clear on write first, then set on reserve, so a same-edge reservation survives.
  always_comb begin
    busy_d = busy_vec;
    if (hs_c) begin
      busy_d[win_c.addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write  <= 1'b0;
      rf_w_addr <= '0;
      rf_in     <= '0;
      busy_vec  <= '0;
    end else begin
      rf_write <= hs_c;
      busy_vec <= busy_d;
      if (hs_c) begin
        rf_w_addr <= win_c.addr;
        rf_in     <= win_c.data;
      end
    end
  end

  assign busy1 = busy_vec[r_addr1];
  assign busy2 = busy_vec[r_addr2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic                clk;
  logic                reset;
  logic                hold;
  logic                a_valid;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_data;
  logic                a_ready;
  logic                b_valid;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                b_ready;
  logic                rsv_valid;
  logic [ADDR_W-1:0]   rsv_addr;
  logic [ADDR_W-1:0]   r_addr1;
  logic [ADDR_W-1:0]   r_addr2;
  logic                busy1;
  logic                busy2;
  logic [NUM_REGS-1:0] busy_vec;
  logic                rf_write;
  logic [ADDR_W-1:0]   rf_w_addr;
  logic [DATA_W-1:0]   rf_in;
  logic                last_grant;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .r_addr1    (r_addr1),
    .r_addr2    (r_addr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .busy_vec   (busy_vec),
    .rf_write   (rf_write),
    .rf_w_addr  (rf_w_addr),
    .rf_in      (rf_in),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; hold = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; r_addr1 = '0; r_addr2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; hold = 1'b0;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h22;
    rsv_valid = 1'b0; rsv_addr = '0; r_addr1 = '0; r_addr2 = '0;
    @(posedge clk); #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
    end
    checks++;
    if ({rf_write, rf_w_addr, rf_in, busy_vec, last_grant} !== {1'b0, 3'd0, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got wr=%b addr=%0d in=%h busy=%h lg=%b expected 0 0 00 00 1",
               rf_write, rf_w_addr, rf_in, busy_vec, last_grant);
    end
    do_reset();
  endtask

  task automatic test_reset_midop();
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 3'd2;
    @(posedge clk); #1;
    rsv_addr = 3'd5;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 3'd6; a_data = 8'h33;
    @(posedge clk); #1;
    checks++;
    if ({rf_write, rf_w_addr, busy_vec} !== {1'b1, 3'd6, 8'h24}) begin
      errors++;
      $display("FAIL midop_setup: got wr=%b addr=%0d busy=%h expected 1 6 24", rf_write, rf_w_addr, busy_vec);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rf_write, rf_w_addr, rf_in, busy_vec, last_grant, a_ready} !==
        {1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset: got wr=%b addr=%0d in=%h busy=%h lg=%b ar=%b expected 0 0 00 00 1 0",
               rf_write, rf_w_addr, rf_in, busy_vec, last_grant, a_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd2; a_data = 8'h0F;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b expected 10", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if ({rf_write, rf_w_addr, rf_in, last_grant} !== {1'b1, 3'd2, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL single_write: got wr=%b addr=%0d in=%h lg=%b expected 1 2 0f 0",
               rf_write, rf_w_addr, rf_in, last_grant);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_write, rf_w_addr, rf_in} !== {1'b0, 3'd2, 8'h0F}) begin
      errors++;
      $display("FAIL single_idle: got wr=%b addr=%0d in=%h expected 0 2 0f", rf_write, rf_w_addr, rf_in);
    end
  endtask

  // Runs straight into test_hold, which relies on B being the last winner.
  task automatic test_tie();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    do_reset();
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 3'd3; b_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_ready[%0d]: got %b", i, {a_ready, b_ready});
      end
      @(posedge clk); #1;
      ea = (i % 2 == 0) ? 3'd1 : 3'd3;
      ed = (i % 2 == 0) ? 8'hAA : 8'h55;
      checks++;
      if ({rf_write, rf_w_addr, rf_in, last_grant} !== {1'b1, ea, ed, 1'(i % 2)}) begin
        errors++;
        $display("FAIL tie_write[%0d]: got wr=%b addr=%0d in=%h lg=%b expected 1 %0d %h %0d",
                 i, rf_write, rf_w_addr, rf_in, last_grant, ea, ed, i % 2);
      end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b expected 00", i, {a_ready, b_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_write, last_grant} !== 2'b01) begin
        errors++; $display("FAIL hold_write[%0d]: got wr=%b lg=%b expected 0 1", i, rf_write, last_grant);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL hold_release: got %b expected 10", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if ({rf_write, rf_w_addr, rf_in, last_grant} !== {1'b1, 3'd1, 8'hAA, 1'b0}) begin
      errors++;
      $display("FAIL hold_write_after: got wr=%b addr=%0d in=%h lg=%b expected 1 1 aa 0",
               rf_write, rf_w_addr, rf_in, last_grant);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 3'd5; r_addr1 = 3'd5; r_addr2 = 3'd4;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    checks++;
    if ({busy_vec, busy1, busy2} !== {8'h20, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sb_reserve: got busy=%h b1=%b b2=%b expected 20 1 0", busy_vec, busy1, busy2);
    end
    rsv_valid = 1'b1;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    checks++;
    if (busy_vec !== 8'h20) begin
      errors++; $display("FAIL sb_rereserve: got %h expected 20", busy_vec);
    end
    a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h77;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if ({rf_write, rf_w_addr, busy_vec, busy1} !== {1'b1, 3'd5, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL sb_clear: got wr=%b addr=%0d busy=%h b1=%b expected 1 5 00 0", rf_write, rf_w_addr, busy_vec, busy1);
    end
    a_valid = 1'b1; a_addr = 3'd0; a_data = 8'h01;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if ({rf_write, busy_vec} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL sb_nonbusy_write: got wr=%b busy=%h expected 1 00", rf_write, busy_vec);
    end
  endtask

  task automatic test_collision();
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 3'd4; r_addr2 = 3'd4;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 8'hC4;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++; $display("FAIL coll_ready: got %b expected 1", b_ready);
    end
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    checks++;
    if ({rf_write, rf_w_addr, rf_in, busy_vec, busy2} !== {1'b1, 3'd4, 8'hC4, 8'h10, 1'b1}) begin
      errors++;
      $display("FAIL coll_set_wins: got wr=%b addr=%0d in=%h busy=%h b2=%b expected 1 4 c4 10 1",
               rf_write, rf_w_addr, rf_in, busy_vec, busy2);
    end
    b_data = 8'hC5;
    @(posedge clk); #1;
    b_valid = 1'b0;
    checks++;
    if ({rf_write, rf_in, busy_vec, busy2} !== {1'b1, 8'hC5, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL coll_second_clear: got wr=%b in=%h busy=%h b2=%b expected 1 c5 00 0",
               rf_write, rf_in, busy_vec, busy2);
    end
  endtask

  // Random traffic against a model built from the arbitration and scoreboard rules.
  task automatic test_random();
    logic                m_last;
    logic                m_wr;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_data;
    logic                m_busy [NUM_REGS];
    logic [NUM_REGS-1:0] eb;
    logic                ga;
    logic                gb;
    do_reset();
    m_last = 1'b1; m_wr = 1'b0; m_addr = '0; m_data = '0;
    for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1; a_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1)); a_data = DATA_W'($urandom);
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1; b_data = DATA_W'($urandom);
        b_addr = ($urandom_range(0, 3) == 0) ? a_addr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      end
      hold      = ($urandom_range(0, 3) == 0);
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      r_addr1   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      r_addr2   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      ga = 1'b0; gb = 1'b0;
      if (!hold) begin
        if (a_valid && b_valid) begin
          if (m_last == GRANT_B) ga = 1'b1; else gb = 1'b1;
        end else if (a_valid) ga = 1'b1;
        else if (b_valid) gb = 1'b1;
      end
      checks++;
      if ({a_ready, b_ready, busy1, busy2} !== {ga, gb, m_busy[r_addr1], m_busy[r_addr2]}) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got ar=%b br=%b b1=%b b2=%b expected %b %b %b %b",
                 c, a_ready, b_ready, busy1, busy2, ga, gb, m_busy[r_addr1], m_busy[r_addr2]);
      end
      @(posedge clk); #1;
      m_wr = ga | gb;
      if (ga) begin
        m_addr = a_addr; m_data = a_data; m_last = GRANT_A; m_busy[a_addr] = 1'b0;
      end
      if (gb) begin
        m_addr = b_addr; m_data = b_data; m_last = GRANT_B; m_busy[b_addr] = 1'b0;
      end
      if (rsv_valid) m_busy[rsv_addr] = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) eb[r] = m_busy[r];
      checks++;
      if ({rf_write, rf_w_addr, rf_in, busy_vec, last_grant} !== {m_wr, m_addr, m_data, eb, m_last}) begin
        errors++;
        $display("FAIL rand_seq[%0d]: got wr=%b addr=%0d in=%h busy=%h lg=%b expected %b %0d %h %h %b",
                 c, rf_write, rf_w_addr, rf_in, busy_vec, last_grant, m_wr, m_addr, m_data, eb, m_last);
      end
      if (ga) a_valid = 1'b0;
      if (gb) b_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_single();
    test_tie();
    test_hold();
    test_scoreboard();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
